fetch_unit: RTL and testbench

Instruction fetch front end that sits between the instruction memory (`imem`) and the decode stage of `mips`. It owns the program counter and issues one word address per cycle to the synchronous-read memory. It pairs each returned word with its PC and presents it to decode with a valid flag. It also handles decode stalls, branch/jump redirects, and out-of-range fetch faults.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_perf.sv | 45 ++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-side constants: instruction memory window and NOP encoding,
// plus the PC legality helper used by the fetch front end.
package fetch_unit_pkg;

  localparam logic [31:0] mem_start = 32'h8002_0000;
  localparam logic [31:0] mem_depth = 32'h0001_0000;
  localparam logic [31:0] nop_instr = 32'h0000_0000;

  // A PC is fetchable when word aligned and inside [lo, hi).
  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (pc[1:0] == 2'b00) && (pc >= lo) && (pc < hi);
  endfunction

endpackage

// File: rtl/fetch_perf.sv
// Delivered-instruction and delivered-bubble counters for the fetch unit.
// Both counters are 32-bit and wrap silently.
module fetch_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetched_inc,
  input  logic        bubble_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] bubbles_q, bubbles_d;

  // Next-count computation; each counter steps by one on its event.
  always_comb begin
    fetched_d = fetched_q;
    bubbles_d = bubbles_q;
    if (fetched_inc) begin
      fetched_d = fetched_q + 32'd1;
    end else begin
      fetched_d = fetched_q;
    end
    if (bubble_inc) begin
      bubbles_d = bubbles_q + 32'd1;
    end else begin
      bubbles_d = bubbles_q;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= 32'd0;
      bubbles_q <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word address per
// cycle to a synchronous-read imem, pairs returned words with their PC and
// handles decode stalls, branch redirects and sticky fetch faults.
// Optional macro FETCH_PERF_EN adds delivered-instruction/bubble counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] pc_init = mem_start,
  parameter logic [31:0] mem_lo  = mem_start,
  parameter logic [31:0] mem_hi  = mem_start + mem_depth
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  logic [31:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        fault_q, fault_d;

  // While stalled the memory re-reads the outstanding request so its word
  // is still on imem_dout when decode releases; a redirect overrides that.
  assign imem_addr = (stall && !redirect_en) ? req_pc_q : pc_q;

  // Next-state logic: redirect beats stall, stall beats fault, fault beats issue.
  always_comb begin
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    fault_d     = fault_q;
    if (redirect_en) begin
      // The wrong-path word arriving now is dropped with the request.
      pc_d        = redirect_pc;
      req_valid_d = 1'b0;
      if_valid_d  = 1'b0;
      fault_d     = 1'b0;
    end else if (stall) begin
      // Everything holds; the memory replays req_pc.
      pc_d = pc_q;
    end else begin
      if_valid_d = req_valid_q;
      if_instr_d = imem_dout;
      if_pc_d    = req_pc_q;
      if (!fault_q && pc_legal(pc_q, mem_lo, mem_hi)) begin
        req_valid_d = 1'b1;
        req_pc_d    = pc_q;
        pc_d        = pc_q + 32'd4;
      end else begin
        req_valid_d = 1'b0;
        fault_d     = 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= pc_init;
      req_valid_q <= 1'b0;
      req_pc_q    <= 32'd0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= nop_instr;
      if_pc_q     <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      fault_q     <= fault_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_fault = fault_q;

`ifdef FETCH_PERF_EN
  logic fetched_inc_s;
  logic bubble_inc_s;

  // Count events: a deliver edge moves req_valid into if_valid, a redirect
  // edge always writes a bubble; stalled edges count nothing.
  always_comb begin
    fetched_inc_s = 1'b0;
    bubble_inc_s  = 1'b0;
    if (redirect_en) begin
      bubble_inc_s = 1'b1;
    end else if (!stall) begin
      fetched_inc_s = req_valid_q;
      bubble_inc_s  = !req_valid_q;
    end else begin
      fetched_inc_s = 1'b0;
      bubble_inc_s  = 1'b0;
    end
  end

  fetch_perf u_perf (
    .clk          (clk),
    .reset        (reset),
    .fetched_inc  (fetched_inc_s),
    .bubble_inc   (bubble_inc_s),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );
`else
  assign perf_fetched = 32'd0;
  assign perf_bubbles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle-level behavioural model of the
// fetch stream, an imem stand-in, a per-cycle compare process and directed
// scenarios with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  localparam logic [31:0] BASE = 32'h8002_0000;
  localparam logic [31:0] HI   = 32'h8002_0100;

  fetch_unit #(.mem_hi(HI)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_dout    (imem_dout),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .fetch_fault  (fetch_fault),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );

  always #5 clk = ~clk;

  // Memory contents: 0x1111_0001 at BASE, +1 per word; junk elsewhere.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a >= BASE && a < HI) return 32'h1111_0001 + ((a - BASE) >> 2);
    else return 32'hDEAD_0000 ^ a;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_dout <= word_at(imem_addr);

  // Behavioural model of the fetch stream.
  logic [31:0] m_next;     // next address to fetch
  bit          m_fly;      // one fetch in flight
  logic [31:0] m_fly_pc;
  bit          m_v;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_fault;
  int unsigned m_fetched, m_bubbles;

  always @(posedge clk) begin
    if (reset) begin
      m_next = BASE; m_fly = 0; m_fly_pc = 32'd0;
      m_v = 0; m_pc = 32'd0; m_instr = 32'd0; m_fault = 0;
      m_fetched = 0; m_bubbles = 0;
    end else if (redirect_en) begin
      m_next = redirect_pc; m_fly = 0; m_v = 0; m_fault = 0;
      m_bubbles++;
    end else if (!stall) begin
      m_v = m_fly;
      if (m_fly) begin
        m_pc = m_fly_pc; m_instr = word_at(m_fly_pc); m_fetched++;
      end else begin
        m_bubbles++;
      end
      if (!m_fault && m_next[1:0] == 2'b00 && m_next >= BASE && m_next < HI) begin
        m_fly = 1; m_fly_pc = m_next; m_next = m_next + 32'd4;
      end else begin
        m_fly = 0; m_fault = 1;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_if_valid", {31'd0, if_valid}, {31'd0, m_v});
      cmp("m_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      cmp("m_imem_addr", imem_addr, (stall && !redirect_en) ? m_fly_pc : m_next);
      if (m_v) begin
        cmp("m_if_pc", if_pc, m_pc);
        cmp("m_if_instr", if_instr, m_instr);
      end
`ifdef FETCH_PERF_EN
      cmp("m_perf_f", perf_fetched, m_fetched);
      cmp("m_perf_b", perf_bubbles, m_bubbles);
`else
      cmp("m_perf_f", perf_fetched, 32'd0);
      cmp("m_perf_b", perf_bubbles, 32'd0);
`endif
    end
  end

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    cmp({nm, "_v"}, {31'd0, if_valid}, {31'd0, v});
    if (v) begin
      cmp({nm, "_pc"}, if_pc, pc);
      cmp({nm, "_ins"}, if_instr, ins);
    end
  endtask

  initial begin
    // Reset values
    edge_();
    chk_en = 1'b1;
    edge_();
    cmp("rst_addr", imem_addr, 32'h8002_0000);
    cmp("rst_v", {31'd0, if_valid}, 32'd0);
    cmp("rst_ins", if_instr, 32'd0);
    cmp("rst_pc", if_pc, 32'd0);
    cmp("rst_flt", {31'd0, fetch_fault}, 32'd0);
    reset = 1'b0;

    // Sequential fetch: first valid two edges after reset release
    edge_(); chk_out("seq0", 1'b0, 32'd0, 32'd0);
    edge_(); chk_out("seq1", 1'b1, 32'h8002_0000, 32'h1111_0001);
    edge_(); chk_out("seq2", 1'b1, 32'h8002_0004, 32'h1111_0002);

    // Stall three cycles while 0x8002_0004 is on the output
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_(); chk_out("stl", 1'b1, 32'h8002_0004, 32'h1111_0002);
    end
    stall = 1'b0;
    edge_(); chk_out("rel", 1'b1, 32'h8002_0008, 32'h1111_0003);

    // Redirect while 0x8002_000C is in flight
    redirect_en = 1'b1; redirect_pc = 32'h8002_0040;
    edge_(); redirect_en = 1'b0;
    chk_out("rd0", 1'b0, 32'd0, 32'd0);
    edge_(); chk_out("rd1", 1'b0, 32'd0, 32'd0);
    edge_(); chk_out("rd2", 1'b1, 32'h8002_0040, 32'h1111_0011);
    edge_(); chk_out("rd3", 1'b1, 32'h8002_0044, 32'h1111_0012);

    // Redirect and stall together: redirect wins
    redirect_en = 1'b1; stall = 1'b1; redirect_pc = 32'h8002_0040;
    edge_(); redirect_en = 1'b0; stall = 1'b0;
    chk_out("rs0", 1'b0, 32'd0, 32'd0);
    edge_(); chk_out("rs1", 1'b0, 32'd0, 32'd0);
    edge_(); chk_out("rs2", 1'b1, 32'h8002_0040, 32'h1111_0011);
    edge_(); chk_out("rs3", 1'b1, 32'h8002_0044, 32'h1111_0012);

    // Misaligned redirect target faults
    redirect_en = 1'b1; redirect_pc = 32'h8002_0002;
    edge_(); redirect_en = 1'b0;
    edge_();
    cmp("mis_flt", {31'd0, fetch_fault}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      edge_(); chk_out("mis_hold", 1'b0, 32'd0, 32'd0);
    end
    cmp("mis_addr", imem_addr, 32'h8002_0002);

    // Legal redirect clears the fault
    redirect_en = 1'b1; redirect_pc = 32'h8002_0000;
    edge_(); redirect_en = 1'b0;
    cmp("clr_flt", {31'd0, fetch_fault}, 32'd0);
    edge_();
    edge_(); chk_out("clr_run", 1'b1, 32'h8002_0000, 32'h1111_0001);

    // Run off the end of the fetchable window
    redirect_en = 1'b1; redirect_pc = 32'h8002_00F0;
    edge_(); redirect_en = 1'b0;
    repeat (4) edge_();
    chk_out("end_f8", 1'b1, 32'h8002_00F8, 32'h1111_003F);
    edge_();
    chk_out("end_fc", 1'b1, 32'h8002_00FC, 32'h1111_0040);
    cmp("end_flt", {31'd0, fetch_fault}, 32'd1);
    edge_();
    chk_out("end_bub", 1'b0, 32'd0, 32'd0);
    cmp("end_addr", imem_addr, 32'h8002_0100);

    // Reset in the middle of a stall
    stall = 1'b1; reset = 1'b1;
    edge_();
    stall = 1'b0;
    #1;
    cmp("rs_v", {31'd0, if_valid}, 32'd0);
    cmp("rs_flt", {31'd0, fetch_fault}, 32'd0);
    cmp("rs_pc", if_pc, 32'd0);
    cmp("rs_ins", if_instr, 32'd0);
    cmp("rs_addr", imem_addr, 32'h8002_0000);
    edge_();
    reset = 1'b0;

    // Counter scenario: 10 sequential, 1 redirect, 2-cycle stall
    repeat (11) edge_();
    chk_out("pf_seq", 1'b1, 32'h8002_0024, 32'h1111_000A);
    redirect_en = 1'b1; redirect_pc = 32'h8002_0040;
    edge_(); redirect_en = 1'b0;
    edge_(); edge_();
    chk_out("pf_rd", 1'b1, 32'h8002_0040, 32'h1111_0011);
    stall = 1'b1;
    edge_(); edge_();
    stall = 1'b0;
`ifdef FETCH_PERF_EN
    cmp("pf_fetched", perf_fetched, 32'd11);
    cmp("pf_bubbles", perf_bubbles, 32'd3);
`else
    cmp("pf_fetched", perf_fetched, 32'd0);
    cmp("pf_bubbles", perf_bubbles, 32'd0);
`endif
    edge_(); chk_out("pf_next", 1'b1, 32'h8002_0044, 32'h1111_0012);
    repeat (3) edge_();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
